// File: rtl/inst_fetch_if.sv
// Byte-wide instruction-memory read bus between the fetch unit and memory.
// The fetch unit (master) raises mem_req with a stable mem_addr; memory
// (slave) returns one byte on mem_rdata in every cycle it raises mem_ack.
interface inst_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/inst_fetch.sv
// Multicycle instruction-fetch unit for the 8-bit-memory MIPS core.
// Assembles one little-endian 32-bit instruction from four byte reads over
// the req/ack bus, holds it in the instruction register and owns the PC.
// The controller pulses fetch_start (optionally with pc_load for a branch)
// while this unit is idle and consumes op/funct when ir_valid pulses.
module inst_fetch #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_next,
    inst_fetch_if.master      mem,
    output logic [31:0]       ir,
    output logic [5:0]        op,
    output logic [5:0]        funct,
    output logic              ir_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] ADDR_FOUR = ADDR_W'(3'd4);

    state_t            state_r;
    state_t            state_s;
    logic [1:0]        idx_r;
    logic [1:0]        idx_s;
    logic              req_r;
    logic              req_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_s;
    logic [31:0]       ir_r;
    logic [31:0]       ir_s;
    logic              valid_r;
    logic              valid_s;
    logic              busy_r;
    logic              busy_s;
    logic              beat_s;

    // Replace one byte lane of the instruction word; lane k holds the byte
    // read from pc+k, so the first byte fetched lands in bits [7:0].
    function automatic logic [31:0] insert_byte(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [7:0]  data
    );
        logic [31:0] result;
        result = word;
        case (lane)
            2'd0:    result[7:0]   = data;
            2'd1:    result[15:8]  = data;
            2'd2:    result[23:16] = data;
            2'd3:    result[31:24] = data;
            default: result        = word;
        endcase
        return result;
    endfunction

    // A byte is transferred only when our request meets the memory's ack;
    // an ack outside FETCH (e.g. a late one after reset) never qualifies.
    assign beat_s = req_r && mem.mem_ack;

    // Next-state and next-register logic for the fetch sequencer.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        req_s   = req_r;
        addr_s  = addr_r;
        pc_s    = pc_r;
        ir_s    = ir_r;
        valid_s = 1'b0;
        busy_s  = busy_r;

        case (state_r)
            ST_IDLE: begin
                // A branch load takes effect immediately, so a fetch started
                // in the same cycle already targets the new PC.
                if (pc_load) begin
                    pc_s = pc_next;
                end else begin
                    pc_s = pc_r;
                end
                if (fetch_start) begin
                    state_s = ST_FETCH;
                    idx_s   = 2'd0;
                    req_s   = 1'b1;
                    busy_s  = 1'b1;
                    addr_s  = pc_load ? pc_next : pc_r;
                end else begin
                    req_s   = 1'b0;
                    busy_s  = 1'b0;
                end
            end

            ST_FETCH: begin
                // Address, lane index and request all hold while memory stalls.
                if (beat_s) begin
                    ir_s   = insert_byte(ir_r, idx_r, mem.mem_rdata);
                    idx_s  = idx_r + 2'd1;
                    addr_s = addr_r + ADDR_ONE;
                    if (idx_r == 2'd3) begin
                        state_s = ST_DONE;
                        req_s   = 1'b0;
                        valid_s = 1'b1;
                    end else begin
                        state_s = ST_FETCH;
                        req_s   = 1'b1;
                    end
                end else begin
                    state_s = ST_FETCH;
                    req_s   = 1'b1;
                end
            end

            ST_DONE: begin
                // The instruction is complete: advance to the sequential PC
                // and release the controller.
                pc_s    = pc_r + ADDR_FOUR;
                state_s = ST_IDLE;
                req_s   = 1'b0;
                busy_s  = 1'b0;
            end

            default: begin
                state_s = ST_IDLE;
                idx_s   = 2'd0;
                req_s   = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // FSM state register; reset aborts any fetch in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered-output registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r   <= 2'd0;
            req_r   <= 1'b0;
            addr_r  <= '0;
            pc_r    <= '0;
            ir_r    <= 32'h0000_0000;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            idx_r   <= idx_s;
            req_r   <= req_s;
            addr_r  <= addr_s;
            pc_r    <= pc_s;
            ir_r    <= ir_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
        end
    end

    assign mem.mem_req  = req_r;
    assign mem.mem_addr = addr_r;

    assign ir       = ir_r;
    assign op       = ir_r[31:26];
    assign funct    = ir_r[5:0];
    assign ir_valid = valid_r;
    assign busy     = busy_r;
    assign pc       = pc_r;
    assign pc_plus4 = pc_r + ADDR_FOUR;

endmodule
